disp_scan_ctrl: RTL

- Sequencing controller for the 4-digit seven-segment display of the signed multiplier result.
- Accepts a 16-bit two's-complement product on a load pulse.
- Converts the magnitude to 5 BCD digits with a multi-cycle double-dabble engine, and keeps the sign.
- Time-multiplexes the 4 anodes by driving the digit-select (toggle) and 4-bit digit code into the existing segment/anode decoder, and supports scrolling a 3-digit window over the 5 magnitude digits.

---
 rtl/disp_scan_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - seven-segment scan controller with double-dabble BCD conversion
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             scroll_left,
  input  logic             scroll_right,
  output logic [1:0]       toggle,
  output logic [3:0]       digit_code,
  output logic             busy,
  output logic             valid
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         toggle_q;
  logic [1:0]         idx_q;
  logic [15:0]        mag_q;
  logic [19:0]        scr_q;
  logic [4:0]         iter_q;
  logic               neg_q;
  logic [19:0]        d_q;
  logic               sign_q;
  logic               valid_q;

  logic [19:0]        scr_adj;
  logic [19:0]        scr_shift;
  logic [15:0]        abs_value;
  logic               commit;
  logic [2:0]         pos;
  logic [3:0]         nib;

  // Magnitude of the two's-complement input; -32768 maps to 32768 unsigned.
  assign abs_value = value[15] ? (~value + 16'd1) : value;
  assign commit    = (state_q == S_CONV) && (iter_q == 5'd1);

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next magnitude bit.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 5; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_shift = {scr_adj[18:0], mag_q[15]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a load starts a conversion, the last iteration returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_CONV;
      S_CONV:  if (iter_q == 5'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    if (state_q == S_CONV) busy = 1'b1;
  end

  // Conversion datapath; committed digits change only on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q   <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      neg_q   <= 1'b0;
      d_q     <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (load) begin
        neg_q  <= value[15];
        mag_q  <= abs_value;
        scr_q  <= '0;
        iter_q <= 5'd16;
      end
    end else begin
      scr_q  <= scr_shift;
      mag_q  <= {mag_q[14:0], 1'b0};
      iter_q <= iter_q - 5'd1;
      if (iter_q == 5'd1) begin
        d_q     <= scr_shift;
        sign_q  <= neg_q;
        valid_q <= 1'b1;
      end
    end
  end

  // Refresh divider and anode slot select, free-running regardless of conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      toggle_q <= '0;
    end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_q    <= '0;
      toggle_q <= toggle_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Scroll window index; a commit resets the window and overrides any scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (commit) begin
      idx_q <= '0;
    end else if (scroll_left && !scroll_right && idx_q != 2'd2) begin
      idx_q <= idx_q + 2'd1;
    end else if (scroll_right && !scroll_left && idx_q != 2'd0) begin
      idx_q <= idx_q - 2'd1;
    end
  end

  // Digit code decode from registered state: sign slot on the left, three windowed digits.
  always_comb begin
    pos = {1'b0, idx_q} + {1'b0, toggle_q};
    case (pos)
      3'd0:    nib = d_q[3:0];
      3'd1:    nib = d_q[7:4];
      3'd2:    nib = d_q[11:8];
      3'd3:    nib = d_q[15:12];
      default: nib = d_q[19:16];
    endcase
    if (!valid_q) begin
      digit_code = 4'd15;
    end else if (toggle_q == 2'd3) begin
      digit_code = sign_q ? 4'd10 : 4'd15;
    end else begin
      digit_code = nib;
    end
  end

  assign toggle = toggle_q;
  assign valid  = valid_q;

endmodule
